// File: rtl/rr_merge_pkg.sv
// Shared types and constants for the 4-way round-robin merge.
// Holds requester count, source id type and a rotation helper.
package rr_merge_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] src_id_t;

  // Requester index k positions after base, modulo 4.
  function automatic src_id_t rot(
    input src_id_t base,
    input src_id_t k
  );
    return base + k;
  endfunction

endpackage

// File: rtl/rr_merge4_if.sv
// Handshake bundle around rr_merge4.
// master drives requests and consumer ready; slave is the merge side.
interface rr_merge4_if #(
  parameter int p_nbits = 32
);
  logic [3:0]         in_val;
  logic [3:0]         in_rdy;
  logic [p_nbits-1:0] in0_msg;
  logic [p_nbits-1:0] in1_msg;
  logic [p_nbits-1:0] in2_msg;
  logic [p_nbits-1:0] in3_msg;
  logic               out_val;
  logic               out_rdy;
  logic [p_nbits-1:0] out_msg;
  logic [1:0]         out_src;

  modport master (
    output in_val, in0_msg, in1_msg,
    output in2_msg, in3_msg, out_rdy,
    input  in_rdy, out_val, out_msg,
    input  out_src
  );

  modport slave (
    input  in_val, in0_msg, in1_msg,
    input  in2_msg, in3_msg, out_rdy,
    output in_rdy, out_val, out_msg,
    output out_src
  );
endinterface

// File: rtl/rr_merge4_arb4.sv
// Round-robin arbiter: priority ptr, ptr+1, ptr+2, ptr+3.
// Ports: req in, en (transfer taken), one-hot grant, grant_idx.
module rr_arb4
  import rr_merge_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output src_id_t         grant_idx
);
  src_id_t ptr_q;
  src_id_t ptr_d;
  src_id_t idx;

  // Scan lowest priority first so the highest
  // priority requester is the last to win.
  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    idx       = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = rot(ptr_q, src_id_t'(k));
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    ptr_d = en ? grant_idx + 2'd1 : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/rr_merge4_mux4.sv
// Library 4-input mux, width p_nbits.
// Ports: in0..in3 data, sel index, out selected data.
module mux4 #(
  parameter int p_nbits = 32
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  input  logic [1:0]         sel,
  output logic [p_nbits-1:0] out
);
  always_comb begin
    unique case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end
endmodule

// File: rtl/rr_merge4.sv
// 4-to-1 round-robin merge with a one-entry output register.
// Ports: clk, reset, in_val/in_rdy/in*_msg, out_val/out_rdy/out_msg/out_src.
module rr_merge4
  import rr_merge_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         in_val,
  output logic [3:0]         in_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic [p_nbits-1:0] in1_msg,
  input  logic [p_nbits-1:0] in2_msg,
  input  logic [p_nbits-1:0] in3_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic [1:0]         out_src
);
  logic [NREQ-1:0]    grant;
  src_id_t            grant_idx;
  logic [p_nbits-1:0] sel_msg;
  logic               can_acc;
  logic               xfer;
  logic               deq;

  logic               full_q, full_d;
  logic [p_nbits-1:0] msg_q, msg_d;
  src_id_t            src_q, src_d;

  rr_arb4 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_val),
    .en        (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  mux4 #(.p_nbits(p_nbits)) u_mux (
    .in0 (in0_msg),
    .in1 (in1_msg),
    .in2 (in2_msg),
    .in3 (in3_msg),
    .sel (grant_idx),
    .out (sel_msg)
  );

  // Register can take a new entry if empty
  // or if it is being drained this cycle.
  assign can_acc = !full_q || out_rdy;
  assign in_rdy  = reset ? '0
                 : grant & {NREQ{can_acc}};
  assign xfer    = |in_rdy;
  assign deq     = full_q && out_rdy;

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    src_d  = src_q;
    if (xfer) begin
      full_d = 1'b1;
      msg_d  = sel_msg;
      src_d  = grant_idx;
    end else if (deq) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      msg_q  <= '0;
      src_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
      src_q  <= src_d;
    end
  end

  assign out_val = full_q;
  assign out_msg = msg_q;
  assign out_src = src_q;
endmodule

// File: tb/tb_rr_merge4.sv
// Self-checking bench for rr_merge4.
// Directed vector table plus random traffic against a queue-level model.
module tb_rr_merge4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_merge4_if #(.p_nbits(W)) bus ();

  rr_merge4 #(.p_nbits(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (bus.in_val),
    .in_rdy  (bus.in_rdy),
    .in0_msg (bus.in0_msg),
    .in1_msg (bus.in1_msg),
    .in2_msg (bus.in2_msg),
    .in3_msg (bus.in3_msg),
    .out_val (bus.out_val),
    .out_rdy (bus.out_rdy),
    .out_msg (bus.out_msg),
    .out_src (bus.out_src)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  val;
    logic        ordy;
    logic [31:0] m2;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [1:0]  e_src;
    logic [31:0] e_msg;
    int          e_ptr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference: one-slot buffer, pointer as an int.
  int          mptr;
  bit          mfull;
  logic [31:0] mmsg;
  int          msrc;
  logic [31:0] msgs [4];

  function automatic int pick(logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(mptr + k) % 4]) return (mptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy(
    logic r, logic [3:0] v, logic o
  );
    int g;
    logic [3:0] res;
    res = 4'b0000;
    g = pick(v);
    if (!r && g >= 0 && (!mfull || o))
      res[g] = 1'b1;
    return res;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic [3:0] v,
                       logic o, logic [31:0] m0,
                       logic [31:0] m1, logic [31:0] m2,
                       logic [31:0] m3);
    reset       = r;
    bus.in_val  = v;
    bus.out_rdy = o;
    bus.in0_msg = m0;
    bus.in1_msg = m1;
    bus.in2_msg = m2;
    bus.in3_msg = m3;
    msgs[0] = m0;
    msgs[1] = m1;
    msgs[2] = m2;
    msgs[3] = m3;
  endtask

  task automatic chk_model();
    chk("m_in_rdy", {28'd0, bus.in_rdy},
        {28'd0, exp_rdy(reset, bus.in_val,
                        bus.out_rdy)});
    chk("m_out_val", {31'd0, bus.out_val},
        {31'd0, mfull});
    chk("m_out_msg", bus.out_msg, mmsg);
    chk("m_out_src", {30'd0, bus.out_src},
        32'(msrc));
    chk("m_ptr", {30'd0, dut.u_arb.ptr_q},
        32'(mptr));
  endtask

  // Advance one clock, updating the model with the
  // inputs that were live at the rising edge.
  task automatic tick();
    int g;
    bit x;
    @(posedge clk);
    if (reset) begin
      mptr = 0; mfull = 0; mmsg = '0; msrc = 0;
    end else begin
      g = pick(bus.in_val);
      x = (g >= 0) && (!mfull || bus.out_rdy);
      if (x) begin
        mmsg  = msgs[g];
        msrc  = g;
        mfull = 1;
        mptr  = (g + 1) % 4;
      end else if (mfull && bus.out_rdy) begin
        mfull = 0;
      end
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(
    logic r, logic [3:0] v, logic o,
    logic [31:0] m2, logic [3:0] er,
    logic eo, logic [1:0] es,
    logic [31:0] em, int ep
  );
    vec_t t;
    t.rst = r; t.val = v; t.ordy = o;
    t.m2 = m2; t.e_rdy = er; t.e_ov = eo;
    t.e_src = es; t.e_msg = em; t.e_ptr = ep;
    return t;
  endfunction

  vec_t tbl [24];

  initial begin
    // reset, round-robin on all four, then drain
    tbl[0]  = mk(1, 4'hF, 1, 32'h102, 4'h0, 0, 0, 32'h0,   0);
    tbl[1]  = mk(0, 4'hF, 1, 32'h102, 4'h1, 0, 0, 32'h0,   0);
    tbl[2]  = mk(0, 4'hF, 1, 32'h102, 4'h2, 1, 0, 32'h100, 1);
    tbl[3]  = mk(0, 4'hF, 1, 32'h102, 4'h4, 1, 1, 32'h101, 2);
    tbl[4]  = mk(0, 4'hF, 1, 32'h102, 4'h8, 1, 2, 32'h102, 3);
    tbl[5]  = mk(0, 4'hF, 1, 32'h102, 4'h1, 1, 3, 32'h103, 0);
    tbl[6]  = mk(0, 4'h0, 1, 32'h102, 4'h0, 1, 0, 32'h100, 1);
    tbl[7]  = mk(0, 4'h0, 1, 32'h102, 4'h0, 0, 0, 32'h100, 1);
    // only requester 2, messages A then B
    tbl[8]  = mk(0, 4'h4, 1, 32'hA,   4'h4, 0, 0, 32'h100, 1);
    tbl[9]  = mk(0, 4'h4, 1, 32'hB,   4'h4, 1, 2, 32'hA,   3);
    tbl[10] = mk(0, 4'h0, 1, 32'h102, 4'h0, 1, 2, 32'hB,   3);
    // ptr=3: requester 1 wins over 2
    tbl[11] = mk(0, 4'h6, 1, 32'h102, 4'h2, 0, 2, 32'hB,   3);
    // stall three cycles with full register
    tbl[12] = mk(0, 4'hF, 0, 32'h102, 4'h0, 1, 1, 32'h101, 2);
    tbl[13] = mk(0, 4'hF, 0, 32'h102, 4'h0, 1, 1, 32'h101, 2);
    tbl[14] = mk(0, 4'hF, 0, 32'h102, 4'h0, 1, 1, 32'h101, 2);
    // release: dequeue and enqueue same cycle
    tbl[15] = mk(0, 4'hF, 1, 32'h102, 4'h4, 1, 1, 32'h101, 2);
    tbl[16] = mk(0, 4'h0, 0, 32'h102, 4'h0, 1, 2, 32'h102, 3);
    // reset with a buffered message
    tbl[17] = mk(1, 4'hF, 0, 32'h102, 4'h0, 1, 2, 32'h102, 3);
    tbl[18] = mk(0, 4'h0, 0, 32'h102, 4'h0, 0, 0, 32'h0,   0);
    // idle for five cycles
    for (int i = 19; i < 24; i++)
      tbl[i] = mk(0, 4'h0, 1, 32'h102, 4'h0, 0, 0, 32'h0, 0);

    drive(1, 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].val, tbl[i].ordy,
            32'h100, 32'h101, tbl[i].m2, 32'h103);
      #1;
      chk($sformatf("t%0d_in_rdy", i),
          {28'd0, bus.in_rdy}, {28'd0, tbl[i].e_rdy});
      chk($sformatf("t%0d_out_val", i),
          {31'd0, bus.out_val}, {31'd0, tbl[i].e_ov});
      chk($sformatf("t%0d_out_src", i),
          {30'd0, bus.out_src}, {30'd0, tbl[i].e_src});
      chk($sformatf("t%0d_out_msg", i),
          bus.out_msg, tbl[i].e_msg);
      chk($sformatf("t%0d_ptr", i),
          {30'd0, dut.u_arb.ptr_q}, 32'(tbl[i].e_ptr));
      chk_model();
      tick();
    end

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 63) == 0,
            4'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom, $urandom, $urandom, $urandom);
      #1;
      chk_model();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_merge4.md
RR_MERGE4 -- requirements
Module: rr_merge4

Interface
REQ-001 SHALL have parameter p_nbits, default 32, giving the message width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_val, input, 4 bits: per-requester valid.
REQ-005 SHALL have port in_rdy, output, 4 bits: per-requester ready.
REQ-006 SHALL have ports in0_msg..in3_msg, input, p_nbits each: requester messages.
REQ-007 SHALL have port out_val, output, 1 bit: output message valid.
REQ-008 SHALL have port out_rdy, input, 1 bit: consumer ready.
REQ-009 SHALL have port out_msg, output, p_nbits: merged message.
REQ-010 SHALL have port out_src, output, 2 bits: index of the requester that supplied out_msg.

Function
REQ-011 SHALL count a transfer on any port only in a cycle where val and rdy are both high.
REQ-012 SHALL hold a 2-bit priority pointer ptr; priority order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-013 SHALL grant the highest-priority requester with in_val set; grant is combinational from in_val and ptr.
REQ-014 SHALL hold a one-entry output register (full flag, msg, src); out_val equals full.
REQ-015 SHALL drive in_rdy[i] = grant[i] AND (NOT full OR out_rdy); at most one in_rdy bit is high per cycle.
REQ-016 SHALL on an input transfer capture the granted message through a 4:1 mux selected by the grant index, and capture src = that index; out_val rises the next cycle (latency 1).
REQ-017 SHALL sustain one transfer per cycle while out_rdy stays high and any in_val is set.
REQ-018 SHALL, on simultaneous output dequeue and input transfer, overwrite the register and keep out_val at 1.
REQ-019 SHALL, on an output dequeue with no input transfer, clear full.
REQ-020 SHALL hold out_msg and out_src stable while out_val=1 and out_rdy=0; all in_rdy bits are 0 in this case.
REQ-021 SHALL update ptr to (grant+1) mod 4 only in a cycle with an input transfer; grant 3 wraps ptr to 0.
REQ-022 SHALL leave ptr unchanged in cycles with no input transfer.
REQ-023 SHALL never make out_val depend combinationally on out_rdy; in_rdy MAY depend combinationally on in_val.

Reset
REQ-024 SHALL, in any cycle with reset high, load ptr=0, full=0, out_msg=0 and out_src=0 at the clock edge.
REQ-025 SHALL force in_rdy=0000 while reset is high.
REQ-026 SHALL discard a buffered message when reset is asserted mid-operation; out_val is 0 in the following cycle.

Structure
REQ-027 SHALL place the constant NREQ=4 and the 2-bit typedef src_id_t in the shared package rr_merge_pkg.
REQ-028 SHALL implement the grant logic plus ptr as the sub-module rr_arb4, with ports clk, reset, req[3:0], en, grant[3:0] and grant_idx.
REQ-029 SHALL implement message selection with the library 4-input mux, parameterised to p_nbits.

Verification
REQ-030 SHALL cover: after reset, all in_val=1111 and out_rdy=1 held -> out_src sequence 0,1,2,3,0 on consecutive cycles, first out_val one cycle after the first transfer.
REQ-031 SHALL cover: only in_val[2] high, messages 0xA then 0xB -> out_msg 0xA then 0xB with out_src=2, and ptr=3 afterwards.
REQ-032 SHALL cover: continuing from REQ-031, in_val=0110 -> requester 1 is granted first (priority order 3,0,1,2).
REQ-033 SHALL cover: register full and out_rdy=0 for 3 cycles with in_val=1111 -> in_rdy=0000 and out_msg/out_src unchanged.
REQ-034 SHALL cover: continuing from REQ-033, out_rdy=1 -> the held message is dequeued and the next grant is enqueued in the same cycle.
REQ-035 SHALL cover: reset asserted while out_val=1 -> out_val=0 and ptr=0 the next cycle, with in_rdy=0000 during reset.
REQ-036 SHALL cover: in_val=0000 for 5 cycles -> out_val stays 0 and ptr is unchanged.
